spike_pattern_sequencer: RTL and testbench

//   Synthesizable, parametrised spike-stimulus player for neuron and STDP cores.

---
 rtl/spike_pattern_sequencer.sv | 165 ++++++++++++++++
 tb/tb_spike_pattern_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_pattern_sequencer.sv
// rtl/spike_pattern_sequencer.sv - replays a table of {spike vector, interval} entries as setup/start/wait steps
`timescale 1ns/1ps
module spike_pattern_sequencer #(
   parameter int NUM_AXONS    = 4,
   parameter int DEPTH        = 8,
   parameter int ADDR_W       = 3,
   parameter int INTERVAL_W   = 8,
   parameter int SETUP_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [NUM_AXONS-1:0]  wr_spike,
   input  logic [INTERVAL_W-1:0] wr_interval,
   input  logic [ADDR_W:0]       num_entries,
   input  logic                  loop_mode,
   input  logic                  run,
   input  logic                  abort,
   output logic [NUM_AXONS-1:0]  spike_out,
   output logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_W-1:0]     cur_idx
);

   typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, FIN} state_t;

   localparam int SW = $clog2(SETUP_CYCLES + 1);

   logic [NUM_AXONS-1:0]  spike_mem [DEPTH];
   logic [INTERVAL_W-1:0] ival_mem  [DEPTH];

   state_t                state_q, state_d;
   logic [SW-1:0]         setup_cnt_q, setup_cnt_d;
   logic [INTERVAL_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [ADDR_W-1:0]     cur_idx_q, cur_idx_d;
   logic [NUM_AXONS-1:0]  vec_q, vec_d;
   logic [INTERVAL_W-1:0] ival_q, ival_d;
   logic [ADDR_W:0]       num_q, num_d;
   logic                  loop_q, loop_d;

   logic                  advance;
   logic                  go_setup;
   logic [ADDR_W-1:0]     nxt_idx;
   logic                  is_last;

   // Table has no reset so its contents survive a mid-run reset.
   always_ff @(posedge clk) begin
      if (wr_en && (int'(wr_addr) < DEPTH)) begin
         spike_mem[wr_addr] <= wr_spike;
         ival_mem[wr_addr]  <= wr_interval;
      end
   end

   assign is_last = ((ADDR_W+1)'(cur_idx_q) + 1'b1) >= num_q;

   always_comb begin
      state_d     = state_q;
      setup_cnt_d = setup_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      cur_idx_d   = cur_idx_q;
      vec_d       = vec_q;
      ival_d      = ival_q;
      num_d       = num_q;
      loop_d      = loop_q;
      advance     = 1'b0;
      go_setup    = 1'b0;
      nxt_idx     = cur_idx_q;

      case (state_q)
         IDLE: begin
            if (run && !abort) begin
               loop_d    = loop_mode;
               cur_idx_d = '0;
               if (num_entries == '0) begin
                  num_d   = '0;
                  state_d = FIN;
               end else begin
                  num_d    = (num_entries > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : num_entries;
                  nxt_idx  = '0;
                  go_setup = 1'b1;
               end
            end
         end
         SETUP: begin
            if (setup_cnt_q == '0) state_d = START;
            else                   setup_cnt_d = setup_cnt_q - 1'b1;
         end
         START: begin
            if (ival_q == '0) begin
               advance = 1'b1;
            end else begin
               wait_cnt_d = ival_q;
               state_d    = WAIT;
            end
         end
         WAIT: begin
            if (wait_cnt_q <= INTERVAL_W'(1)) advance = 1'b1;
            else                              wait_cnt_d = wait_cnt_q - 1'b1;
         end
         FIN: begin
            state_d   = IDLE;
            cur_idx_d = '0;
         end
         default: state_d = IDLE;
      endcase

      if (advance) begin
         if (!is_last) begin
            nxt_idx  = cur_idx_q + 1'b1;
            go_setup = 1'b1;
         end else if (loop_q) begin
            nxt_idx  = '0;
            go_setup = 1'b1;
         end else begin
            state_d   = FIN;
            cur_idx_d = '0;
         end
      end

      // Entry snapshot taken here, so later table writes only affect the next play.
      if (go_setup) begin
         state_d     = SETUP;
         cur_idx_d   = nxt_idx;
         vec_d       = spike_mem[nxt_idx];
         ival_d      = ival_mem[nxt_idx];
         setup_cnt_d = SW'(SETUP_CYCLES - 1);
      end

      if (abort && (state_q != IDLE)) begin
         state_d   = IDLE;
         cur_idx_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         setup_cnt_q <= '0;
         wait_cnt_q  <= '0;
         cur_idx_q   <= '0;
         vec_q       <= '0;
         ival_q      <= '0;
         num_q       <= '0;
         loop_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         setup_cnt_q <= setup_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         cur_idx_q   <= cur_idx_d;
         vec_q       <= vec_d;
         ival_q      <= ival_d;
         num_q       <= num_d;
         loop_q      <= loop_d;
      end
   end

   assign spike_out = (state_q == SETUP || state_q == START || state_q == WAIT) ? vec_q : '0;
   assign start     = (state_q == START);
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == FIN);
   assign cur_idx   = cur_idx_q;

endmodule

// File: tb/tb_spike_pattern_sequencer.sv
// tb/tb_spike_pattern_sequencer.sv - scoreboard bench for spike_pattern_sequencer
`timescale 1ns/1ps
module tb_spike_pattern_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_en = 1'b0;
   logic [2:0] wr_addr = '0;
   logic [3:0] wr_spike = '0;
   logic [7:0] wr_interval = '0;
   logic [3:0] num_entries = '0;
   logic       loop_mode = 1'b0;
   logic       run = 1'b0;
   logic       abort = 1'b0;
   logic [3:0] spike_out;
   logic       start;
   logic       busy;
   logic       done;
   logic [2:0] cur_idx;

   spike_pattern_sequencer dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_spike(wr_spike), .wr_interval(wr_interval), .num_entries(num_entries),
      .loop_mode(loop_mode), .run(run), .abort(abort), .spike_out(spike_out),
      .start(start), .busy(busy), .done(done), .cur_idx(cur_idx)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] sp;
      logic [2:0] idx;
      int         gap;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   last_start = 0;
   logic [3:0] sp1 = '0;
   logic [3:0] sp2 = '0;

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Start monitor: each start pulse pops one expected entry.
   always @(negedge clk) begin
      exp_t e;
      if (start === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_start", 32'(cur_idx), 32'hFFFF_FFFF);
         end else begin
            e = sb.pop_front();
            check("start_idx", 32'(cur_idx), 32'(e.idx));
            check("start_spike", 32'(spike_out), 32'(e.sp));
            check("setup_spike", 32'(sp2), 32'(e.sp));
            if (e.gap != 0) check("start_gap", 32'(cyc - last_start), 32'(e.gap));
         end
         last_start = cyc;
      end
      sp2 = sp1;
      sp1 = spike_out;
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wr(input int a, input logic [3:0] s, input logic [7:0] iv);
      wr_en = 1'b1;
      wr_addr = a[2:0];
      wr_spike = s;
      wr_interval = iv;
      step();
      wr_en = 1'b0;
   endtask

   task automatic push(input logic [3:0] s, input logic [2:0] i, input int g);
      exp_t e;
      e.sp = s;
      e.idx = i;
      e.gap = g;
      sb.push_back(e);
   endtask

   task automatic pulse_run();
      run = 1'b1;
      step();
      run = 1'b0;
   endtask

   task automatic wait_done(input int max, input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < max && !seen; i++) begin
         step();
         if (done === 1'b1) seen = 1'b1;
      end
      check(tag, 32'(seen), 32'd1);
   endtask

   task automatic wait_sb(input int left, input int max, input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < max && !ok; i++) begin
         step();
         if (sb.size() == left) ok = 1'b1;
      end
      check(tag, 32'(ok), 32'd1);
   endtask

   initial begin
      bit saw_done;
      logic [3:0] t1 [5];
      t1[0] = 4'b1111; t1[1] = 4'b0010; t1[2] = 4'b1100; t1[3] = 4'b0100; t1[4] = 4'b0101;

      step(); step();
      check("rst_spike", 32'(spike_out), 32'd0);
      check("rst_start", 32'(start), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_idx", 32'(cur_idx), 32'd0);
      rst_n = 1'b1;
      step();

      // 1: five entries, interval 100, single shot
      for (int i = 0; i < 5; i++) begin
         wr(i, t1[i], 8'd100);
         push(t1[i], 3'(i), (i == 0) ? 0 : 103);
      end
      num_entries = 4'd5;
      loop_mode = 1'b0;
      pulse_run();
      wait_done(700, "t1_done");
      check("t1_done_lat", 32'(cyc - last_start), 32'd101);
      check("t1_done_spike", 32'(spike_out), 32'd0);
      check("t1_done_idx", 32'(cur_idx), 32'd0);
      check("t1_sb_empty", 32'(sb.size()), 32'd0);
      step();
      check("t1_idle", 32'(busy), 32'd0);

      // 2: zero interval, single entry
      wr(0, 4'b1010, 8'd0);
      push(4'b1010, 3'd0, 0);
      num_entries = 4'd1;
      pulse_run();
      check("t2_setup1_spike", 32'(spike_out), 32'hA);
      check("t2_setup1_start", 32'(start), 32'd0);
      step();
      check("t2_setup2_start", 32'(start), 32'd0);
      step();
      check("t2_start", 32'(start), 32'd1);
      step();
      check("t2_done", 32'(done), 32'd1);
      check("t2_done_spike", 32'(spike_out), 32'd0);
      step();

      // 3: loop mode, abort mid-WAIT
      wr(0, 4'b0001, 8'd5);
      wr(1, 4'b0010, 8'd5);
      push(4'b0001, 3'd0, 0);
      push(4'b0010, 3'd1, 8);
      push(4'b0001, 3'd0, 8);
      push(4'b0010, 3'd1, 8);
      num_entries = 4'd2;
      loop_mode = 1'b1;
      pulse_run();
      wait_sb(0, 100, "t3_starts");
      step(); step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("t3_abort_busy", 32'(busy), 32'd0);
      check("t3_abort_spike", 32'(spike_out), 32'd0);
      saw_done = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done === 1'b1) saw_done = 1'b1;
         step();
      end
      check("t3_no_done", 32'(saw_done), 32'd0);

      // 4: zero entries, then clamp 9 -> 8
      num_entries = 4'd0;
      loop_mode = 1'b0;
      pulse_run();
      check("t4_zero_done", 32'(done), 32'd1);
      check("t4_zero_start", 32'(start), 32'd0);
      step();
      check("t4_zero_idle", 32'(busy), 32'd0);
      for (int i = 0; i < 8; i++) begin
         wr(i, 4'(i + 1), 8'd1);
         push(4'(i + 1), 3'(i), (i == 0) ? 0 : 4);
      end
      num_entries = 4'd9;
      pulse_run();
      wait_done(100, "t4_clamp_done");
      check("t4_clamp_sb", 32'(sb.size()), 32'd0);
      step();

      // 5: rewrite entry 1 during its WAIT
      wr(0, 4'b0011, 8'd10);
      wr(1, 4'b0110, 8'd10);
      push(4'b0011, 3'd0, 0);
      push(4'b0110, 3'd1, 13);
      push(4'b0011, 3'd0, 13);
      push(4'b1001, 3'd1, 13);
      num_entries = 4'd2;
      loop_mode = 1'b1;
      pulse_run();
      wait_sb(2, 100, "t5_first_pass");
      step();
      wr(1, 4'b1001, 8'd10);
      check("t5_held_spike", 32'(spike_out), 32'h6);
      check("t5_held_idx", 32'(cur_idx), 32'd1);
      wait_sb(0, 100, "t5_second_pass");
      step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("t5_abort_busy", 32'(busy), 32'd0);

      // 6: asynchronous reset during SETUP, table retained
      num_entries = 4'd2;
      loop_mode = 1'b0;
      pulse_run();
      check("t6_setup_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_spike", 32'(spike_out), 32'd0);
      check("t6_rst_busy", 32'(busy), 32'd0);
      check("t6_rst_start", 32'(start), 32'd0);
      check("t6_rst_idx", 32'(cur_idx), 32'd0);
      step();
      rst_n = 1'b1;
      step();
      push(4'b0011, 3'd0, 0);
      push(4'b1001, 3'd1, 13);
      pulse_run();
      wait_done(100, "t6_done");
      check("t6_sb_empty", 32'(sb.size()), 32'd0);
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
